io_stream_write_array: RTL and testbench

//  Counterpart of the stream-to-array reader: streams a contiguous region of an Array out
//  on a stream interface, one element per beat.

---
 rtl/io_stream_write_array_if.sv | 37 +++
 rtl/io_stream_write_array.sv | 136 +++++++++++++
 tb/tb_io_stream_write_array.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_stream_write_array_if.sv
// Bundle for io_stream_write_array: caller handshake, array read port and output stream.
// slave is the streamer's view; master is the surrounding environment's view.
interface io_stream_write_array_if #(
  parameter int INT_N  = 8,
  parameter int ADDR_N = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_N-1:0] base;
  logic [ADDR_N-1:0] len;
  logic [ADDR_N-1:0] count;

  logic [ADDR_N-1:0] arr_addr;
  logic              arr_we;
  logic [INT_N-1:0]  arr_di;
  logic [INT_N-1:0]  arr_do;
  logic              arr_valid;
  logic              arr_ready;

  logic [INT_N-1:0]  sOut;
  logic              sOut_valid;
  logic              sOut_ready;

  modport slave (
    input  in_valid, out_ready, base, len, arr_do, arr_ready, sOut_ready,
    output in_ready, out_valid, count, arr_addr, arr_we, arr_di, arr_valid,
           sOut, sOut_valid
  );

  modport master (
    output in_valid, out_ready, base, len, arr_do, arr_ready, sOut_ready,
    input  in_ready, out_valid, count, arr_addr, arr_we, arr_di, arr_valid,
           sOut, sOut_valid
  );
endinterface

// File: rtl/io_stream_write_array.sv
// Streams array[base .. base+len-1] out one element per beat, overlapping reads with
// output through a 2-entry buffer whose head register drives the stream directly.
//
// state | meaning
// IDLE  | waiting for a start request, in_ready high
// RUN   | issuing array reads, buffer may also be emitting beats
// DRAIN | all reads accepted, emptying in-flight data and buffer
// DONE  | completion presented with count until out_ready
module io_stream_write_array #(
  parameter int INT_N  = 8,
  parameter int ADDR_N = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  io_stream_write_array_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_N-1:0] addr_q, addr_d;
  logic [ADDR_N-1:0] rem_q, rem_d;
  logic [ADDR_N-1:0] count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [INT_N-1:0]  head_q, head_d;
  logic [INT_N-1:0]  tail_q, tail_d;

  logic              pop;
  logic [1:0]        used;
  logic              arr_valid_c;
  logic              req_fire;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    count_d    = count_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;

    pop = (occ_q != 2'd0) && bus.sOut_ready;
    // A beat leaving this cycle frees its slot before the new read can land.
    used        = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    arr_valid_c = (state_q == S_RUN) && (used < 2'd2);
    req_fire    = arr_valid_c && bus.arr_ready;
    inflight_d  = req_fire;

    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus.arr_do;
        else               tail_d = bus.arr_do;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.arr_do;
        end else begin
          head_d = tail_q;
          tail_d = bus.arr_do;
        end
      end
      default: ;
    endcase

    if (pop) count_d = count_q + ADDR_N'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          addr_d  = bus.base;
          rem_d   = bus.len;
          count_d = '0;
          state_d = (bus.len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (req_fire) begin
          addr_d = addr_q + ADDR_N'(1);
          rem_d  = rem_q - ADDR_N'(1);
          if (rem_q == ADDR_N'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_d == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.count      = count_q;
  assign bus.arr_addr   = addr_q;
  assign bus.arr_we     = 1'b0;
  assign bus.arr_di     = '0;
  assign bus.arr_valid  = arr_valid_c;
  assign bus.sOut       = head_q;
  assign bus.sOut_valid = (occ_q != 2'd0);

endmodule

// File: tb/tb_io_stream_write_array.sv
// Randomized bench for io_stream_write_array: array responder, queue-based reference
// model with a single per-cycle compare process, and directed literal checks.
module tb_io_stream_write_array;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  io_stream_write_array_if #(.INT_N(8), .ADDR_N(8)) bus ();

  io_stream_write_array #(.INT_N(8), .ADDR_N(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  logic [7:0] mem [256];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  bit         m_busy = 0;
  int         m_len, m_base, m_req, m_beat;
  logic [7:0] exp_q [$];
  logic [7:0] got   [$];
  int         t_start, t_first, t_last, t_ov, ov_count;
  bit         done_seen;
  bit         p_arr_stall, p_s_stall;
  logic [7:0] p_addr, p_sout;
  bit         pend;
  logic [7:0] paddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Array: read data appears the cycle after an accepted request, garbage otherwise.
  always @(negedge clk) begin
    pend  = nrst && bus.arr_valid && bus.arr_ready;
    paddr = bus.arr_addr;
  end
  always @(posedge clk) begin
    #1;
    bus.arr_do = pend ? mem[paddr] : 8'($urandom);
  end

  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_in_ready",   32'(bus.in_ready),   1);
      chk("rst_out_valid",  32'(bus.out_valid),  0);
      chk("rst_arr_valid",  32'(bus.arr_valid),  0);
      chk("rst_sout_valid", 32'(bus.sOut_valid), 0);
      chk("rst_count",      32'(bus.count),      0);
      chk("rst_arr_addr",   32'(bus.arr_addr),   0);
      m_busy      = 0;
      exp_q.delete();
      p_arr_stall = 0;
      p_s_stall   = 0;
    end else begin
      chk("in_ready",  32'(bus.in_ready),  32'(!m_busy));
      chk("out_valid", 32'(bus.out_valid), 32'(m_busy && (m_beat == m_len)));
      if (bus.out_valid) chk("count", 32'(bus.count), 32'(m_len));
      chk("arr_we_di", {23'd0, bus.arr_we, bus.arr_di}, 0);
      chk("outstanding_le2", 32'((m_req - m_beat) <= 2), 1);
      if (bus.arr_valid) begin
        chk("arr_in_range", 32'(m_busy && (m_req < m_len)), 1);
        chk("arr_addr", 32'(bus.arr_addr), 32'((m_base + m_req) % 256));
      end
      if (!m_busy) chk("idle_quiet", 32'(bus.arr_valid || bus.sOut_valid), 0);
      if (p_arr_stall) begin
        chk("arr_hold_valid", 32'(bus.arr_valid), 1);
        chk("arr_hold_addr",  32'(bus.arr_addr),  32'(p_addr));
      end
      if (p_s_stall) begin
        chk("sout_hold_valid", 32'(bus.sOut_valid), 1);
        chk("sout_hold_data",  32'(bus.sOut),       32'(p_sout));
      end
      if (bus.sOut_valid && bus.sOut_ready) begin
        if (exp_q.size() == 0) chk("sout_extra_beat", 32'(exp_q.size()), 1);
        else                   chk("sout_data", 32'(bus.sOut), 32'(exp_q.pop_front()));
        got.push_back(bus.sOut);
        if (m_beat == 0) t_first = cyc;
        t_last = cyc;
        m_beat++;
      end
      if (bus.arr_valid && bus.arr_ready) m_req++;
      if (bus.out_valid && t_ov < 0) begin
        t_ov     = cyc;
        ov_count = 32'(bus.count);
      end
      if (bus.out_valid && bus.out_ready) begin
        m_busy    = 0;
        done_seen = 1;
      end
      if (bus.in_valid && bus.in_ready) begin
        m_busy  = 1;
        m_base  = 32'(bus.base);
        m_len   = 32'(bus.len);
        m_req   = 0;
        m_beat  = 0;
        t_start = cyc;
        t_ov    = -1;
        exp_q.delete();
        got.delete();
        for (int i = 0; i < m_len; i++) exp_q.push_back(mem[8'(m_base + i)]);
      end
      p_arr_stall = bus.arr_valid && !bus.arr_ready;
      p_addr      = bus.arr_addr;
      p_s_stall   = bus.sOut_valid && !bus.sOut_ready;
      p_sout      = bus.sOut;
    end
  end

  task automatic start_call(input int b, input int l);
    @(posedge clk); #1;
    done_seen    = 0;
    bus.base     = 8'(b);
    bus.len      = 8'(l);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.base     = 8'($urandom);
    bus.len      = 8'($urandom);
  endtask

  // ar_mode: 0 ready, 1 random, 2 stalled 5 cycles early in the call
  // sr_mode: 0 ready, 1 one cycle in three, 2 random
  task automatic wait_done(input int ar_mode, input int sr_mode, input bit stray);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_seen) begin
        ok = 1;
        break;
      end
      case (ar_mode)
        0:       bus.arr_ready = 1'b1;
        1:       bus.arr_ready = ($urandom_range(0, 9) < 7);
        default: bus.arr_ready = !(i >= 3 && i < 8);
      endcase
      case (sr_mode)
        0:       bus.sOut_ready = 1'b1;
        1:       bus.sOut_ready = (cyc % 3 == 0);
        default: bus.sOut_ready = ($urandom_range(0, 9) < 6);
      endcase
      bus.out_ready = (ar_mode == 0 && sr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_valid  = stray && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("call_completes", 32'(ok), 1);
  endtask

  initial begin
    nrst           = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.arr_ready  = 1'b1;
    bus.sOut_ready = 1'b1;
    bus.base       = '0;
    bus.len        = '0;
    bus.arr_do     = '0;
    t_ov           = -1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)  mem[i] = 8'(i);
    #1 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // 1: full-rate stream of 0..15
    start_call(0, 16);
    wait_done(0, 0, 0);
    chk("t1_beats", 32'(got.size()), 16);
    for (int k = 0; k < 16 && k < got.size(); k++) chk("t1_value", 32'(got[k]), 32'(k));
    chk("t1_first_latency", 32'(t_first - t_start), 3);
    chk("t1_throughput",    32'(t_last - t_first),  15);
    chk("t1_done_latency",  32'(t_ov - t_start),    19);
    chk("t1_count",         32'(ov_count),          16);

    // 2: consumer ready one cycle in three
    start_call(0, 16);
    wait_done(0, 1, 0);
    chk("t2_beats", 32'(got.size()), 16);
    for (int k = 0; k < 16 && k < got.size(); k++) chk("t2_value", 32'(got[k]), 32'(k));

    // 3: address wrap
    mem[254] = 8'hA1; mem[255] = 8'hB2; mem[0] = 8'hC3; mem[1] = 8'hD4;
    start_call(254, 4);
    wait_done(0, 0, 0);
    chk("t3_beats", 32'(got.size()), 4);
    if (got.size() == 4) begin
      chk("t3_b0", 32'(got[0]), 32'h A1);
      chk("t3_b1", 32'(got[1]), 32'h B2);
      chk("t3_b2", 32'(got[2]), 32'h C3);
      chk("t3_b3", 32'(got[3]), 32'h D4);
    end

    // 4: empty call
    start_call(7, 0);
    wait_done(0, 0, 0);
    chk("t4_beats",        32'(got.size()),      0);
    chk("t4_done_latency", 32'(t_ov - t_start),  1);
    chk("t4_count",        32'(ov_count),        0);

    // 5: array stalled mid-run
    start_call(40, 8);
    wait_done(2, 0, 0);
    chk("t5_beats", 32'(got.size()), 8);
    chk("t5_count", 32'(ov_count),   8);

    // 6: reset after three beats, then a fresh short call
    bus.arr_ready  = 1'b1;
    bus.sOut_ready = 1'b1;
    bus.out_ready  = 1'b1;
    start_call(0, 10);
    for (int i = 0; i < 50 && got.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("t6_beats_before_reset", 32'(got.size()), 3);
    nrst = 1'b0;
    #1;
    chk("t6_rst_outputs", {27'd0, bus.arr_valid, bus.sOut_valid, bus.out_valid,
                           bus.in_ready, 1'b0} | 32'(bus.count), 32'h2);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    start_call(5, 2);
    wait_done(0, 0, 0);
    chk("t6_fresh_beats", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("t6_fresh_b0", 32'(got[0]), 32'(mem[5]));
      chk("t6_fresh_b1", 32'(got[1]), 32'(mem[6]));
    end

    // Random calls with random backpressure and stray start requests
    for (int n = 0; n < 30; n++) begin
      int b, l;
      b = $urandom_range(0, 255);
      l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      start_call(b, l);
      wait_done($urandom_range(0, 2), $urandom_range(0, 2), 1);
      chk("rand_beats", 32'(got.size()), 32'(l));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
